// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control sequencer for the stopwatch datapath.
// Generates the 1 Hz / 2 Hz tick pulses, synchronises and debounces the
// board inputs, runs the PAUSED/RUN/ADJ state machine and produces the
// one-cycle count, adjust and clear enables for the datapath.
module stopwatch_ctrl #(
    parameter int DIV_1HZ = 100_000_000,
    parameter int DIV_2HZ = 50_000_000,
    parameter int DB_CYC  = 1_000_000
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       btn_pause_raw,
    input  logic       btn_clr_raw,
    input  logic       switch_adj,
    input  logic       switch_sel,
    output logic       tick_1hz,
    output logic       tick_2hz,
    output logic       blink,
    output logic       cnt_en,
    output logic       adj_sec_en,
    output logic       adj_min_en,
    output logic       clr,
    output logic [1:0] state_out,
    output logic       is_adj,
    output logic       is_sel_sec
);

    localparam int W1  = (DIV_1HZ > 1) ? $clog2(DIV_1HZ) : 1;
    localparam int W2  = (DIV_2HZ > 1) ? $clog2(DIV_2HZ) : 1;
    localparam int DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    localparam logic [W1-1:0]  T1_MAX = W1'(DIV_1HZ - 1);
    localparam logic [W1-1:0]  T1_ONE = W1'(1);
    localparam logic [W2-1:0]  T2_MAX = W2'(DIV_2HZ - 1);
    localparam logic [W2-1:0]  T2_ONE = W2'(1);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYC - 1);
    localparam logic [DBW-1:0] DB_ONE = DBW'(1);

    typedef enum logic [1:0] {
        ST_PAUSED = 2'b00,
        ST_RUN    = 2'b01,
        ST_ADJ    = 2'b10
    } state_t;

    // Bit order of the synchronised input vector: 0 pause, 1 clear, 2 adj, 3 sel.
    logic [3:0]     sync1_r;
    logic [3:0]     sync2_r;
    logic [DBW-1:0] db_cnt_r [2];
    logic [1:0]     stable_r;
    logic [1:0]     stable_d_r;
    logic [1:0]     press_s;
    logic [W1-1:0]  t1_cnt_r;
    logic [W2-1:0]  t2_cnt_r;
    logic           tick_1hz_r;
    logic           tick_2hz_r;
    logic           blink_r;
    state_t         state_r;
    logic           clr_r;
    logic           adj_sync_s;
    logic           sel_sync_s;

    // Two-flop synchronisers for every asynchronous board input.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= {switch_sel, switch_adj, btn_clr_raw, btn_pause_raw};
            sync2_r <= sync1_r;
        end
    end

    assign adj_sync_s = sync2_r[2];
    assign sel_sync_s = sync2_r[3];

    // Button debouncers: accept a new level after DB_CYC consecutive differing samples.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= '0;
            end
            stable_r   <= 2'b00;
            stable_d_r <= 2'b00;
        end else begin
            stable_d_r <= stable_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == stable_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_MAX) begin
                    stable_r[i] <= sync2_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                end
            end
        end
    end

    // One-cycle press pulses on the rising edge of each debounced level.
    assign press_s = stable_r & ~stable_d_r;

    // Free-running tick dividers; blink flips with every 2 Hz tick.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            t1_cnt_r   <= '0;
            t2_cnt_r   <= '0;
            tick_1hz_r <= 1'b0;
            tick_2hz_r <= 1'b0;
            blink_r    <= 1'b0;
        end else begin
            if (t1_cnt_r == T1_MAX) begin
                t1_cnt_r   <= '0;
                tick_1hz_r <= 1'b1;
            end else begin
                t1_cnt_r   <= t1_cnt_r + T1_ONE;
                tick_1hz_r <= 1'b0;
            end
            if (t2_cnt_r == T2_MAX) begin
                t2_cnt_r   <= '0;
                tick_2hz_r <= 1'b1;
                blink_r    <= ~blink_r;
            end else begin
                t2_cnt_r   <= t2_cnt_r + T2_ONE;
                tick_2hz_r <= 1'b0;
                blink_r    <= blink_r;
            end
        end
    end

    // Mode state machine: clear beats the adjust switch, which beats pause.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_PAUSED;
            clr_r   <= 1'b0;
        end else begin
            clr_r <= press_s[1];
            if (press_s[1]) begin
                state_r <= adj_sync_s ? ST_ADJ : ST_PAUSED;
            end else begin
                case (state_r)
                    ST_PAUSED: begin
                        if (adj_sync_s) begin
                            state_r <= ST_ADJ;
                        end else if (press_s[0]) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_PAUSED;
                        end
                    end
                    ST_RUN: begin
                        if (adj_sync_s) begin
                            state_r <= ST_ADJ;
                        end else if (press_s[0]) begin
                            state_r <= ST_PAUSED;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_ADJ: begin
                        // Leaving adjust always parks in PAUSED; counting is never resumed here.
                        state_r <= adj_sync_s ? ST_ADJ : ST_PAUSED;
                    end
                    default: begin
                        state_r <= ST_PAUSED;
                    end
                endcase
            end
        end
    end

    // Datapath enables are decoded from registered state and registered ticks only.
    assign cnt_en     = tick_1hz_r & (state_r == ST_RUN) & ~clr_r;
    assign adj_sec_en = tick_2hz_r & (state_r == ST_ADJ) & stable_r[0] & sel_sync_s & ~clr_r;
    assign adj_min_en = tick_2hz_r & (state_r == ST_ADJ) & stable_r[0] & ~sel_sync_s & ~clr_r;

    assign tick_1hz   = tick_1hz_r;
    assign tick_2hz   = tick_2hz_r;
    assign blink      = blink_r;
    assign clr        = clr_r;
    assign state_out  = state_r;
    assign is_adj     = (state_r == ST_ADJ);
    assign is_sel_sec = sel_sync_s;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with small dividers (10 / 5) and a 4-sample debounce.
module tb_stopwatch_ctrl;

    localparam int DIV1 = 10;
    localparam int DIV2 = 5;
    localparam int DB   = 4;

    logic       clk_100mhz;
    logic       rst_n;
    logic       btn_pause_raw;
    logic       btn_clr_raw;
    logic       switch_adj;
    logic       switch_sel;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       blink;
    logic       cnt_en;
    logic       adj_sec_en;
    logic       adj_min_en;
    logic       clr;
    logic [1:0] state_out;
    logic       is_adj;
    logic       is_sel_sec;

    stopwatch_ctrl #(.DIV_1HZ(DIV1), .DIV_2HZ(DIV2), .DB_CYC(DB)) dut (
        .clk_100mhz   (clk_100mhz),
        .rst_n        (rst_n),
        .btn_pause_raw(btn_pause_raw),
        .btn_clr_raw  (btn_clr_raw),
        .switch_adj   (switch_adj),
        .switch_sel   (switch_sel),
        .tick_1hz     (tick_1hz),
        .tick_2hz     (tick_2hz),
        .blink        (blink),
        .cnt_en       (cnt_en),
        .adj_sec_en   (adj_sec_en),
        .adj_min_en   (adj_min_en),
        .clr          (clr),
        .state_out    (state_out),
        .is_adj       (is_adj),
        .is_sel_sec   (is_sel_sec)
    );

    initial begin
        clk_100mhz = 1'b0;
        forever #5 clk_100mhz = ~clk_100mhz;
    end

    int checks = 0;
    int errors = 0;

    // Behavioural reference: time since reset release, input sample history,
    // per-button run length of disagreeing samples, and the mode.
    int          m_c;
    logic [3:0]  m_h1, m_h2;
    logic [1:0]  m_stab, m_press;
    int          m_run [2];
    int          m_mode;
    logic        m_clr;
    logic [10:0] m_exp;

    int acc_cnt, acc_sec, acc_min, acc_clr, acc_overlap;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] dut_vec();
        return {tick_1hz, tick_2hz, blink, cnt_en, adj_sec_en, adj_min_en, clr,
                state_out, is_adj, is_sel_sec};
    endfunction

    task automatic model_reset();
        m_c = 0;
        m_h1 = 4'b0000;
        m_h2 = 4'b0000;
        m_stab = 2'b00;
        m_press = 2'b00;
        m_run[0] = 0;
        m_run[1] = 0;
        m_mode = 0;
        m_clr = 1'b0;
        m_exp = 11'd0;
    endtask

    task automatic model_edge();
        logic [3:0] seen;
        logic [1:0] prev;
        logic t1, t2, bl, sel_now;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // Synchronised values as seen at this edge were sampled two edges ago.
        seen = m_h2;
        // Mode rules: clear first, then the adjust switch, then the pause button.
        m_clr = m_press[1];
        if (m_press[1])          m_mode = seen[2] ? 2 : 0;
        else if (seen[2])        m_mode = 2;
        else if (m_mode == 2)    m_mode = 0;
        else if (m_press[0])     m_mode = (m_mode == 0) ? 1 : 0;
        // A button level is accepted after DB disagreeing samples in a row.
        prev = m_stab;
        for (int b = 0; b < 2; b++) begin
            if (seen[b] == m_stab[b]) begin
                m_run[b] = 0;
            end else begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_stab[b] = seen[b];
                    m_run[b] = 0;
                end
            end
        end
        m_press = m_stab & ~prev;
        m_h2 = m_h1;
        m_h1 = {switch_sel, switch_adj, btn_clr_raw, btn_pause_raw};
        m_c++;
        t1 = (m_c % DIV1 == 0);
        t2 = (m_c % DIV2 == 0);
        bl = ((m_c / DIV2) % 2 == 1);
        sel_now = m_h2[3];
        m_exp = {t1, t2, bl,
                 t1 && m_mode == 1 && !m_clr,
                 t2 && m_mode == 2 && m_stab[0] && sel_now && !m_clr,
                 t2 && m_mode == 2 && m_stab[0] && !sel_now && !m_clr,
                 m_clr, 2'(m_mode), (m_mode == 2), sel_now};
    endtask

    task automatic step();
        logic [10:0] act;
        @(posedge clk_100mhz);
        model_edge();
        #1;
        act = dut_vec();
        checks++;
        if (act !== m_exp) begin
            errors++;
            $display("FAIL cycle_model t=%0t actual=%b expected=%b", $time, act, m_exp);
        end
        acc_cnt     += int'(cnt_en);
        acc_sec     += int'(adj_sec_en);
        acc_min     += int'(adj_min_en);
        acc_clr     += int'(clr);
        acc_overlap += int'(cnt_en & clr);
    endtask

    task automatic clear_acc();
        acc_cnt = 0; acc_sec = 0; acc_min = 0; acc_clr = 0; acc_overlap = 0;
    endtask

    task automatic set_in(input logic p, input logic c, input logic a, input logic s);
        btn_pause_raw = p;
        btn_clr_raw   = c;
        switch_adj    = a;
        switch_sel    = s;
    endtask

    typedef struct {
        int   n;
        logic pause, clrb, adj, sel;
        int   exp_state;
        int   exp_cnt;   // -1: not checked for this phase
        int   exp_adj;
        int   exp_clr;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        int first1, first2, firstp;
        vecs[0] = '{12,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0,  0, 0};
        vecs[1] = '{2,   1'b1, 1'b0, 1'b0, 1'b0, 0, 0,  0, 0};   // bounce high
        vecs[2] = '{2,   1'b0, 1'b0, 1'b0, 1'b0, 0, 0,  0, 0};   // bounce low
        vecs[3] = '{10,  1'b1, 1'b0, 1'b0, 1'b0, 1, 0,  0, 0};   // settle: one press
        vecs[4] = '{100, 1'b1, 1'b0, 1'b0, 1'b0, 1, 10, 0, 0};   // held, running
        vecs[5] = '{10,  1'b0, 1'b0, 1'b0, 1'b0, 1, -1, 0, 0};   // release: no press
        vecs[6] = '{10,  1'b1, 1'b0, 1'b0, 1'b0, 0, -1, 0, 0};   // second press pauses
        vecs[7] = '{100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0,  0, 0};   // paused: no counts
        vecs[8] = '{10,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0,  0, 0};
        vecs[9] = '{10,  1'b0, 1'b0, 1'b1, 1'b1, 2, 0,  0, 0};   // enter adjust

        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        clear_acc();

        // Reset: outputs all zero while held.
        repeat (3) step();
        chk("reset_outputs", int'(dut_vec()), 0);
        rst_n = 1'b1;

        // Tick phase after release.
        first1 = -1; first2 = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (tick_1hz && first1 < 0) first1 = k;
            if (tick_2hz && first2 < 0) first2 = k;
        end
        chk("first_tick_1hz", first1, 10);
        chk("first_tick_2hz", first2, 5);

        // Table-driven phases.
        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].pause, vecs[i].clrb, vecs[i].adj, vecs[i].sel);
            clear_acc();
            repeat (vecs[i].n) step();
            chk($sformatf("vec%0d_state", i), int'(state_out), vecs[i].exp_state);
            if (vecs[i].exp_cnt >= 0) chk($sformatf("vec%0d_cnt_en", i), acc_cnt, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_adj", i), acc_sec + acc_min, vecs[i].exp_adj);
            chk($sformatf("vec%0d_clr", i), acc_clr, vecs[i].exp_clr);
        end

        // Adjust seconds: 30-cycle hold -> 6 pulses, state stays ADJ.
        clear_acc();
        set_in(1'b1, 1'b0, 1'b1, 1'b1); repeat (30) step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1); repeat (10) step();
        chk("adj_sec_count", acc_sec, 6);
        chk("adj_sec_min_count", acc_min, 0);
        chk("adj_sec_state", int'(state_out), 2);

        // Adjust minutes with sel=0.
        set_in(1'b0, 1'b0, 1'b1, 1'b0); repeat (10) step();
        clear_acc();
        set_in(1'b1, 1'b0, 1'b1, 1'b0); repeat (30) step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0); repeat (10) step();
        chk("adj_min_count", acc_min, 6);
        chk("adj_min_sec_count", acc_sec, 0);

        // Leaving adjust parks in PAUSED.
        set_in(1'b0, 1'b0, 1'b0, 1'b0); repeat (10) step();
        chk("adj_exit_state", int'(state_out), 0);

        // Priority: clear and pause together while running.
        set_in(1'b1, 1'b0, 1'b0, 1'b0); repeat (10) step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0); repeat (10) step();
        chk("prio_run_state", int'(state_out), 1);
        clear_acc();
        set_in(1'b1, 1'b1, 1'b0, 1'b0); repeat (10) step();
        chk("prio_clr_pulses", acc_clr, 1);
        chk("prio_overlap", acc_overlap, 0);
        chk("prio_state", int'(state_out), 0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0); repeat (10) step();

        // Priority again with the adjust switch on.
        set_in(1'b1, 1'b0, 1'b0, 1'b0); repeat (10) step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0); repeat (10) step();
        clear_acc();
        set_in(1'b1, 1'b1, 1'b1, 1'b0); repeat (10) step();
        chk("prio_adj_clr_pulses", acc_clr, 1);
        chk("prio_adj_state", int'(state_out), 2);
        set_in(1'b0, 1'b0, 1'b0, 1'b0); repeat (10) step();

        // Mid-operation reset with the pause button held.
        set_in(1'b1, 1'b0, 1'b0, 1'b0); repeat (10) step();
        chk("midrst_run_state", int'(state_out), 1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_immediate_zero", int'(dut_vec()), 0);
        repeat (3) step();
        rst_n = 1'b1;
        firstp = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (state_out == 2'b01 && firstp < 0) firstp = k;
        end
        chk("midrst_press_latency", firstp, 2 + DB + 1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0); repeat (10) step();

        // Randomised stimulus against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)   btn_pause_raw = ~btn_pause_raw;
            if ($urandom_range(0, 29) == 0)  btn_clr_raw   = ~btn_clr_raw;
            if ($urandom_range(0, 199) == 0) switch_adj    = ~switch_adj;
            if ($urandom_range(0, 49) == 0)  switch_sel    = ~switch_sel;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
